sum_n: RTL

- Parametrised serial accumulator: after a start request, sums NUM_SAMPLES input words, presents the total and pulses done, then returns to idle awaiting the next start.
- Generalises the fixed three-word/8-bit summer: configurable data width, sum width and sample count, a d_valid qualifier for bubbled input streams, a sample counter and a completion strobe.
- Used by the statmchs example designs as a reusable reduction stage.

---
 rtl/sum_n.sv | 133 +++++++++++++
 1 files changed

// File: rtl/sum_n.sv
// sum_n: parametrised serial accumulator.
// After a start request, sums NUM_SAMPLES input words qualified by d_valid,
// presents the total, pulses done for one cycle, and returns to idle.
// Optional build macro SUM_N_SAT_EN: saturating addition with a sticky ovf flag.
// Without it, the sum wraps modulo 2**SUM_W and ovf is tied low.
//
// state | meaning
// ------+---------------------------------------------------------------
// IDLE  | ready high, waiting for start; previous result held
// ACC   | accepting d on d_valid; first word loads, later words add
// DONE  | one-cycle done strobe, final total on sum
module sum_n #(
  parameter int DATA_W      = 8,
  parameter int SUM_W       = 10,
  parameter int NUM_SAMPLES = 4,
  parameter int CNT_W       = 3
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              start,
  input  logic [DATA_W-1:0] d,
  input  logic              d_valid,
  output logic [SUM_W-1:0]  sum,
  output logic              ready,
  output logic              done,
  output logic [CNT_W-1:0]  count,
  output logic              ovf
);

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_ACC  = 2'd1,
    S_DONE = 2'd2
  } state_t;

  state_t            state_q;
  logic [SUM_W-1:0]  sum_q;
  logic [CNT_W-1:0]  count_q;
  logic              ready_q;
  logic              done_q;

  logic [SUM_W-1:0]  d_ext;
  logic [SUM_W-1:0]  sum_add_d;
  logic              last_d;

  // Widen the incoming word and flag the final sample of the operation
  assign d_ext  = SUM_W'(d);
  assign last_d = (count_q == CNT_W'(NUM_SAMPLES - 1));

`ifdef SUM_N_SAT_EN
  logic              ovf_q;
  logic [SUM_W:0]    add_wide_d;
  logic              ovf_set_d;

  // Add with a carry bit so an overflowing add clamps to all-ones
  always_comb begin
    add_wide_d = {1'b0, sum_q} + {1'b0, d_ext};
    ovf_set_d  = add_wide_d[SUM_W];
    sum_add_d  = add_wide_d[SUM_W] ? {SUM_W{1'b1}} : add_wide_d[SUM_W-1:0];
  end

  assign ovf = ovf_q;
`else
  // Plain modulo-2**SUM_W addition
  always_comb begin
    sum_add_d = sum_q + d_ext;
  end

  assign ovf = 1'b0;
`endif

  // Controller: state, accumulator, counter and registered Moore outputs
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q <= S_IDLE;
      sum_q   <= '0;
      count_q <= '0;
      ready_q <= 1'b1;
      done_q  <= 1'b0;
`ifdef SUM_N_SAT_EN
      ovf_q   <= 1'b0;
`endif
    end else begin
      case (state_q)
        S_IDLE: begin
          done_q <= 1'b0;
          if (start) begin
            state_q <= S_ACC;
            count_q <= '0;
            ready_q <= 1'b0;
          end
        end
        S_ACC: begin
          if (d_valid) begin
            count_q <= count_q + CNT_W'(1);
            if (count_q == '0) begin
              // first word of an operation loads and clears overflow history
              sum_q <= d_ext;
`ifdef SUM_N_SAT_EN
              ovf_q <= 1'b0;
`endif
            end else begin
              sum_q <= sum_add_d;
`ifdef SUM_N_SAT_EN
              ovf_q <= ovf_q | ovf_set_d;
`endif
            end
            if (last_d) begin
              state_q <= S_DONE;
              done_q  <= 1'b1;
            end
          end
        end
        S_DONE: begin
          state_q <= S_IDLE;
          done_q  <= 1'b0;
          ready_q <= 1'b1;
        end
        default: begin
          state_q <= S_IDLE;
          done_q  <= 1'b0;
          ready_q <= 1'b1;
        end
      endcase
    end
  end

  assign sum   = sum_q;
  assign count = count_q;
  assign ready = ready_q;
  assign done  = done_q;

endmodule
